macro_decinc4_sched: RTL

MACRO_DECINC4_SCHED -- requirements
Module: macro_decinc4_sched

---
 rtl/macro_decinc4_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/macro_decinc4_sched.sv
// Two-requester round-robin scheduler driving a 4-bit inc/dec counter through a ROM.
// Define MACRO_DECINC4_SCHED_WRAP_EN to let the counter wrap; otherwise it saturates on wrap.

module macro_rom_decinc4 (
    input  logic [3:0] d,
    input  logic       dec,
    output logic [3:0] q,
    output logic       c
);
    always_comb begin
        q = 4'd0;
        c = 1'b0;
        if (dec) begin
            q = d - 4'd1;
            c = (d == 4'd0);
        end else begin
            q = d + 4'd1;
            c = (d == 4'd15);
        end
    end
endmodule

module macro_decinc4_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       a_valid,
    input  logic       a_dec,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_dec,
    output logic       b_ready,
    output logic [3:0] cnt,
    output logic       empty,
    output logic       full,
    output logic       err,
    output logic       last_grant
);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       last_grant_q, last_grant_d;

    logic       grant_a, grant_b, accept, dec_sel;
    logic [3:0] rom_val;
    logic       rom_carry;

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !clr) begin
            grant_a = a_valid && (!b_valid || last_grant_q);
            grant_b = b_valid && (!a_valid || !last_grant_q);
        end
    end

    assign accept  = grant_a | grant_b;
    assign dec_sel = grant_b ? b_dec : a_dec;

    macro_rom_decinc4 u_rom (
        .d   (cnt_q),
        .dec (dec_sel),
        .q   (rom_val),
        .c   (rom_carry)
    );

    always_comb begin
        cnt_d        = cnt_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        if (clr) begin
            cnt_d = 4'd0;
            err_d = 1'b0;
        end else if (accept) begin
            last_grant_d = grant_b;
            if (rom_carry) begin
                err_d = 1'b1;
`ifdef MACRO_DECINC4_SCHED_WRAP_EN
                cnt_d = rom_val;
`else
                cnt_d = cnt_q;
`endif
            end else begin
                cnt_d = rom_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign cnt        = cnt_q;
    assign err        = err_q;
    assign last_grant = last_grant_q;
    assign empty      = (cnt_q == 4'd0);
    assign full       = (cnt_q == 4'd15);
endmodule
